rtc_read_sequencer: RTL

//  Upstream feeder of the double-buffered register memory. Periodically reads 9 time/timer registers

---
 rtl/rtc_read_sequencer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/rtc_read_sequencer.sv
// rtl/rtc_read_sequencer.sv - periodic RTC register reader feeding memory slots 0..8
module rtc_read_sequencer #(
    parameter int T_PULSE = 4,
    parameter int T_GAP   = 2,
    parameter int PERIOD  = 50_000_000,
    parameter int T_HOLD  = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] bus_in,
    output logic [7:0] bus_out,
    output logic       bus_oe,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       ad,
    output logic       whileT,
    output logic [3:0] ADD1,
    output logic [7:0] DAT1,
    output logic       w1,
    output logic       busy,
    output logic       done
);

    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_OPEN, S_ADDR, S_GAP1, S_DATA, S_WRITE, S_GAP2, S_CLOSE, S_HOLD
    } state_t;

    state_t          state_q, state_d, nxt;
    logic [15:0]     tmr_q, tmr_d, dur;
    logic [3:0]      idx_q, idx_d;
    logic [7:0]      smp_q, smp_d;
    logic            pend_q, pend_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            tick, trig, last;

    // RTC register address read for each memory slot
    function automatic logic [7:0] rtc_addr(input logic [3:0] slot);
        case (slot)
            4'd0:    rtc_addr = 8'h21;
            4'd1:    rtc_addr = 8'h22;
            4'd2:    rtc_addr = 8'h23;
            4'd3:    rtc_addr = 8'h24;
            4'd4:    rtc_addr = 8'h25;
            4'd5:    rtc_addr = 8'h26;
            4'd6:    rtc_addr = 8'h41;
            4'd7:    rtc_addr = 8'h42;
            default: rtc_addr = 8'h43;
        endcase
    endfunction

    assign tick = (cnt_q == CW'(PERIOD - 1));
    assign trig = start | tick;

    // State, phase timer, slot index, captured byte, pending flag and period counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            idx_q   <= '0;
            smp_q   <= '0;
            pend_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            idx_q   <= idx_d;
            smp_q   <= smp_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: each phase lasts 'dur' cycles, then moves on to 'nxt'
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q + 16'd1;
        idx_d   = idx_q;
        smp_d   = smp_q;
        pend_d  = pend_q;
        cnt_d   = tick ? '0 : cnt_q + CW'(1);
        dur     = 16'd1;
        nxt     = S_IDLE;
        case (state_q)
            S_OPEN:  begin dur = 16'd2;          nxt = S_ADDR;  end
            S_ADDR:  begin dur = 16'(T_PULSE);   nxt = S_GAP1;  end
            S_GAP1:  begin dur = 16'(T_GAP);     nxt = S_DATA;  end
            S_DATA:  begin dur = 16'(T_PULSE);   nxt = S_WRITE; end
            S_WRITE: begin dur = 16'd1;          nxt = (idx_q == 4'd8) ? S_CLOSE : S_GAP2; end
            S_GAP2:  begin dur = 16'(T_GAP);     nxt = S_ADDR;  end
            S_CLOSE: begin dur = 16'd1;          nxt = S_HOLD;  end
            S_HOLD:  begin dur = 16'(T_HOLD);    nxt = S_IDLE;  end
            default: begin dur = 16'd1;          nxt = S_IDLE;  end
        endcase
        last = (tmr_q == dur - 16'd1);
        if (state_q == S_IDLE) begin
            tmr_d = '0;
            if (trig || pend_q) begin
                state_d = S_OPEN;
                pend_d  = 1'b0;
            end
        end else begin
            // A trigger during a burst or its hold time is remembered once
            if (trig) begin
                pend_d = 1'b1;
            end
            if (last) begin
                state_d = nxt;
                tmr_d   = '0;
                if (state_q == S_DATA) begin
                    smp_d = bus_in;
                end
                if (state_q == S_WRITE && idx_q != 4'd8) begin
                    idx_d = idx_q + 4'd1;
                end
                if (state_q == S_CLOSE) begin
                    idx_d = '0;
                end
            end
        end
    end

    // Outputs decoded from state only, so strobes change only on phase boundaries
    always_comb begin
        bus_out = 8'h00;
        bus_oe  = 1'b0;
        cs_n    = 1'b1;
        rd_n    = 1'b1;
        wr_n    = 1'b1;
        ad      = 1'b0;
        whileT  = 1'b0;
        ADD1    = 4'd15;
        DAT1    = 8'h00;
        w1      = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_OPEN, S_GAP1, S_GAP2: begin
                whileT = 1'b1;
                busy   = 1'b1;
            end
            S_ADDR: begin
                whileT  = 1'b1;
                busy    = 1'b1;
                cs_n    = 1'b0;
                wr_n    = 1'b0;
                bus_oe  = 1'b1;
                bus_out = rtc_addr(idx_q);
            end
            S_DATA: begin
                whileT = 1'b1;
                busy   = 1'b1;
                cs_n   = 1'b0;
                rd_n   = 1'b0;
                ad     = 1'b1;
            end
            S_WRITE: begin
                whileT = 1'b1;
                busy   = 1'b1;
                ADD1   = idx_q;
                DAT1   = smp_q;
                w1     = 1'b1;
            end
            S_CLOSE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            S_HOLD: begin
                busy = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule
